// File: rtl/mcu_el2_pkg.sv
// Shared types and default geometry for the EL2 DCCM SRAM sink.
package mcu_el2_pkg;

    typedef enum logic {
        FILL,
        READY
    } sink_state_e;

    // Default DCCM geometry, mirroring the core's memory parameter set.
    localparam int MCU_DCCM_NUM_BANKS = 4;
    localparam int MCU_DCCM_DATA_W    = 32;
    localparam int MCU_DCCM_ECC_W     = 7;
    localparam int MCU_DCCM_ADDR_W    = 12;

endpackage

// File: rtl/mcu_el2_sram_bank.sv
// One DCCM bank: 1RW array, registered read port that holds between reads.
module mcu_el2_sram_bank #(
    parameter int WORD_W = 39,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [WORD_W-1:0] i_rmask,
    output logic [WORD_W-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    // Array has no reset; the top's fill engine initialises it.
    always_ff @(posedge clk) begin
        if (i_en && i_we)
            r_mem[i_addr] <= i_wdata;
    end

    // The mask only touches the read path; stored contents stay clean.
    always_ff @(posedge clk) begin
        if (rst)
            r_rdata <= '0;
        else if (i_en && !i_we)
            r_rdata <= r_mem[i_addr] ^ i_rmask;
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mcu_el2_dccm_sram_sink.sv
// DCCM SRAM sink: per-bank arrays, post-reset zero-fill FSM and one-shot read error injector.
module mcu_el2_dccm_sram_sink
    import mcu_el2_pkg::*;
#(
    parameter int                      NUM_BANKS = MCU_DCCM_NUM_BANKS,
    parameter int                      DATA_W    = MCU_DCCM_DATA_W,
    parameter int                      ECC_W     = MCU_DCCM_ECC_W,
    parameter int                      ADDR_W    = MCU_DCCM_ADDR_W,
    parameter logic [ECC_W-1:0]        INIT_ECC  = '0,
    localparam int                     BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int                     WORD_W    = DATA_W + ECC_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_BANKS-1:0]        dccm_clken,
    input  logic [NUM_BANKS-1:0]        dccm_wren_bank,
    input  logic [NUM_BANKS*ADDR_W-1:0] dccm_addr_bank,
    input  logic [NUM_BANKS*DATA_W-1:0] dccm_wr_data_bank,
    input  logic [NUM_BANKS*ECC_W-1:0]  dccm_wr_ecc_bank,
    output logic [NUM_BANKS*DATA_W-1:0] dccm_bank_dout,
    output logic [NUM_BANKS*ECC_W-1:0]  dccm_bank_ecc,
    output logic                        init_done,
    input  logic                        inject_req,
    input  logic [BANK_W-1:0]           inject_bank,
    input  logic [WORD_W-1:0]           inject_mask,
    output logic                        inject_armed
);

    sink_state_e        r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_fill_idx;
    logic               w_filling;
    logic               r_armed;
    logic [BANK_W-1:0]  r_inj_bank;
    logic [WORD_W-1:0]  r_inj_mask;
    logic [NUM_BANKS-1:0] w_rd_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FILL;
            r_fill_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_filling)
                r_fill_idx <= r_fill_idx + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_filling   = 1'b0;
        case (r_state)
            FILL: begin
                w_filling = 1'b1;
                if (r_fill_idx == ADDR_W'((1 << ADDR_W) - 1))
                    w_state_nxt = READY;
            end
            READY:   w_state_nxt = READY;
            default: w_state_nxt = FILL;
        endcase
    end

    // Arming wins only when idle; a pending arm is consumed by the first target read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed    <= 1'b0;
            r_inj_bank <= '0;
            r_inj_mask <= '0;
        end else if (!r_armed) begin
            if (inject_req) begin
                r_armed    <= 1'b1;
                r_inj_bank <= inject_bank;
                r_inj_mask <= inject_mask;
            end
        end else if (|w_rd_hit) begin
            r_armed <= 1'b0;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic              w_en, w_we;
        logic [ADDR_W-1:0] w_addr;
        logic [WORD_W-1:0] w_wdata, w_rmask, w_rdata;

        assign w_en    = w_filling | dccm_clken[b];
        assign w_we    = w_filling | dccm_wren_bank[b];
        assign w_addr  = w_filling ? r_fill_idx : dccm_addr_bank[b*ADDR_W +: ADDR_W];
        assign w_wdata = w_filling ? {INIT_ECC, {DATA_W{1'b0}}}
                                   : {dccm_wr_ecc_bank[b*ECC_W +: ECC_W],
                                      dccm_wr_data_bank[b*DATA_W +: DATA_W]};
        assign w_rd_hit[b] = !w_filling && dccm_clken[b] && !dccm_wren_bank[b] &&
                             r_armed && (r_inj_bank == BANK_W'(b));
        assign w_rmask = w_rd_hit[b] ? r_inj_mask : '0;

        mcu_el2_sram_bank #(
            .WORD_W (WORD_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .i_en    (w_en),
            .i_we    (w_we),
            .i_addr  (w_addr),
            .i_wdata (w_wdata),
            .i_rmask (w_rmask),
            .o_rdata (w_rdata)
        );

        assign dccm_bank_dout[b*DATA_W +: DATA_W] = w_rdata[DATA_W-1:0];
        assign dccm_bank_ecc[b*ECC_W +: ECC_W]    = w_rdata[WORD_W-1:DATA_W];
    end

    assign init_done    = (r_state == READY);
    assign inject_armed = r_armed;

endmodule

// File: tb/tb_mcu_el2_dccm_sram_sink.sv
// Scoreboard bench for the DCCM SRAM sink: fill timing, per-bank R/W, injector, mid-fill reset.
module tb_mcu_el2_dccm_sram_sink;

    localparam int NB    = 4;
    localparam int DW    = 32;
    localparam int EW    = 7;
    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;
    localparam int W     = DW + EW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NB-1:0]     clken, wren;
    logic [NB*AW-1:0]  addr_f;
    logic [NB*DW-1:0]  wd_f;
    logic [NB*EW-1:0]  we_f;
    logic [NB*DW-1:0]  dout_f;
    logic [NB*EW-1:0]  ecc_f;
    logic              init_done;
    logic              inject_req;
    logic [1:0]        inject_bank;
    logic [W-1:0]      inject_mask;
    logic              inject_armed;

    mcu_el2_dccm_sram_sink dut (
        .clk               (clk),
        .rst               (rst),
        .dccm_clken        (clken),
        .dccm_wren_bank    (wren),
        .dccm_addr_bank    (addr_f),
        .dccm_wr_data_bank (wd_f),
        .dccm_wr_ecc_bank  (we_f),
        .dccm_bank_dout    (dout_f),
        .dccm_bank_ecc     (ecc_f),
        .init_done         (init_done),
        .inject_req        (inject_req),
        .inject_bank       (inject_bank),
        .inject_mask       (inject_mask),
        .inject_armed      (inject_armed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]    model [NB][DEPTH];
    logic [AW-1:0]   a [NB];
    logic [DW-1:0]   d [NB];
    logic [EW-1:0]   e [NB];
    bit              t_armed;
    logic [1:0]      t_bank;
    logic [W-1:0]    t_mask;

    typedef struct {
        int           bank;
        logic [W-1:0] val;
    } exp_t;
    exp_t sb[$];

    function automatic logic [W-1:0] got(input int b);
        return {ecc_f[b*EW +: EW], dout_f[b*DW +: DW]};
    endfunction

    task automatic model_clear();
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < DEPTH; i++)
                model[b][i] = '0;
        t_armed = 1'b0;
        sb.delete();
    endtask

    // One access cycle from a negedge; reads are scored at the following negedge.
    task automatic apply(input logic [NB-1:0] ce, input logic [NB-1:0] we, input bit req,
                         input logic [1:0] ib, input logic [W-1:0] im);
        bit   hit;
        exp_t x;
        hit = 1'b0;
        for (int b = 0; b < NB; b++) begin
            clken[b] = ce[b];
            wren[b]  = we[b];
            addr_f[b*AW +: AW] = a[b];
            wd_f[b*DW +: DW]   = d[b];
            we_f[b*EW +: EW]   = e[b];
            if (ce[b] && we[b]) begin
                model[b][a[b]] = {e[b], d[b]};
            end else if (ce[b]) begin
                x.bank = b;
                x.val  = model[b][a[b]];
                if (t_armed && t_bank == 2'(b)) begin
                    x.val = x.val ^ t_mask;
                    hit   = 1'b1;
                end
                sb.push_back(x);
            end
        end
        inject_req  = req;
        inject_bank = ib;
        inject_mask = im;
        if (t_armed) begin
            if (hit) t_armed = 1'b0;
        end else if (req) begin
            t_armed = 1'b1;
            t_bank  = ib;
            t_mask  = im;
        end
        @(posedge clk);
        @(negedge clk);
        clken      = '0;
        wren       = '0;
        inject_req = 1'b0;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if (got(x.bank) !== x.val) begin
                errors++;
                $display("FAIL read bank%0d got %h exp %h", x.bank, got(x.bank), x.val);
            end
        end
        checks++;
        if (inject_armed !== t_armed) begin
            errors++;
            $display("FAIL inject_armed got %b exp %b", inject_armed, t_armed);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        checks++;
        if (dout_f !== '0 || ecc_f !== '0 || init_done !== 1'b0 || inject_armed !== 1'b0) begin
            errors++;
            $display("FAIL reset_state dout %h ecc %h done %b armed %b exp all zero",
                     dout_f, ecc_f, init_done, inject_armed);
        end
        rst = 1'b0;
        model_clear();
    endtask

    // Bounded wait for fill completion; core reads during fill must be ignored.
    task automatic wait_fill(input bit inj);
        for (int i = 1; i <= DEPTH; i++) begin
            clken = '1;
            wren  = '0;
            if (inj && i == 50) begin
                inject_req  = 1'b1;
                inject_bank = 2'd3;
                inject_mask = {7'h41, 32'h8000_0001};
                t_armed = 1'b1;
                t_bank  = 2'd3;
                t_mask  = {7'h41, 32'h8000_0001};
            end
            @(posedge clk);
            @(negedge clk);
            inject_req = 1'b0;
            if (i == DEPTH - 1) begin
                checks++;
                if (init_done !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_early init_done got %b exp 0 at cycle %0d", init_done, i);
                end
            end
        end
        clken = '0;
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL fill_done init_done got %b exp 1 after %0d cycles", init_done, DEPTH);
        end
        checks++;
        if (dout_f !== '0 || ecc_f !== '0) begin
            errors++;
            $display("FAIL fill_dout got %h/%h exp 0", dout_f, ecc_f);
        end
    endtask

    task automatic test_reset();
        do_reset(3);
        wait_fill(1'b0);
        for (int b = 0; b < NB; b++) a[b] = '0;
        apply('1, '0, 1'b0, 2'd0, '0);
        for (int b = 0; b < NB; b++) a[b] = AW'(DEPTH - 1);
        apply('1, '0, 1'b0, 2'd0, '0);
    endtask

    task automatic test_write_read();
        logic [W-1:0] held;
        a[0] = 12'd5; d[0] = 32'hDEAD_BEEF; e[0] = 7'h2A;
        apply(4'b0001, 4'b0001, 1'b0, 2'd0, '0);
        apply(4'b0001, 4'b0000, 1'b0, 2'd0, '0);
        held = {7'h2A, 32'hDEAD_BEEF};
        a[0] = 12'd9; d[0] = 32'h1234_5678; e[0] = 7'h11;
        apply(4'b0001, 4'b0001, 1'b0, 2'd0, '0);
        apply(4'b0000, 4'b0000, 1'b0, 2'd0, '0);
        checks++;
        if (got(0) !== held) begin
            errors++;
            $display("FAIL hold bank0 got %h exp %h", got(0), held);
        end
    endtask

    task automatic test_all_banks();
        for (int b = 0; b < NB; b++) begin
            a[b] = AW'(100 + 17 * b);
            d[b] = $urandom();
            e[b] = 7'($urandom_range(0, 127));
        end
        apply('1, '1, 1'b0, 2'd0, '0);
        apply('1, '0, 1'b0, 2'd0, '0);
    endtask

    task automatic test_inject();
        a[2] = 12'd7; d[2] = 32'h1; e[2] = 7'h0;
        apply(4'b0100, 4'b0100, 1'b0, 2'd0, '0);
        apply(4'b0000, 4'b0000, 1'b1, 2'd2, 39'h1);
        apply(4'b0100, 4'b0000, 1'b0, 2'd0, '0);
        apply(4'b0100, 4'b0000, 1'b0, 2'd0, '0);
        // Arm in the same cycle as a target read: that read stays clean.
        apply(4'b0100, 4'b0000, 1'b1, 2'd2, {7'h04, 32'h0});
        apply(4'b0100, 4'b0000, 1'b0, 2'd0, '0);
    endtask

    task automatic test_double_inject();
        a[2] = 12'd7;
        apply(4'b0000, 4'b0000, 1'b1, 2'd2, 39'h1);
        apply(4'b0000, 4'b0000, 1'b1, 2'd2, 39'h10);
        a[2] = 12'd8; d[2] = 32'hCAFE_0000; e[2] = 7'h55;
        apply(4'b0100, 4'b0100, 1'b0, 2'd0, '0);
        apply(4'b0011, 4'b0000, 1'b0, 2'd0, '0);
        apply(4'b0100, 4'b0000, 1'b0, 2'd0, '0);
        apply(4'b0100, 4'b0000, 1'b0, 2'd0, '0);
        apply(4'b0000, 4'b0000, 1'b1, 2'd1, '0);
        a[1] = 12'd5;
        apply(4'b0010, 4'b0000, 1'b0, 2'd0, '0);
    endtask

    task automatic test_midfill_reset();
        a[1] = 12'd3; d[1] = 32'hA5A5_5A5A; e[1] = 7'h3C;
        apply(4'b0010, 4'b0010, 1'b0, 2'd0, '0);
        apply(4'b0010, 4'b0000, 1'b0, 2'd0, '0);
        do_reset(3);
        repeat (100) @(negedge clk);
        do_reset(1);
        wait_fill(1'b1);
        a[1] = 12'd3;
        apply(4'b0010, 4'b0000, 1'b0, 2'd0, '0);
        a[3] = 12'd0;
        apply(4'b1000, 4'b0000, 1'b0, 2'd0, '0);
    endtask

    initial begin
        rst         = 1'b1;
        clken       = '0;
        wren        = '0;
        addr_f      = '0;
        wd_f        = '0;
        we_f        = '0;
        inject_req  = 1'b0;
        inject_bank = '0;
        inject_mask = '0;
        for (int b = 0; b < NB; b++) begin
            a[b] = '0; d[b] = '0; e[b] = '0;
        end
        model_clear();
        test_reset();
        test_write_read();
        test_all_banks();
        test_inject();
        test_double_inject();
        test_midfill_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
